// File: rtl/mac_ve5_fp_int.sv
// mac_ve5_fp_int: value*weight + bias slice, compact-float mode or packed signed-integer modes.
// Latency: 2 cycles (S1 products/alignment, S2 bias add + normalize); one beat accepted per cycle.
// Backpressure: none, never stalls. Define MAC_VE5_SAT_EN for a saturating integer sum (default wraps).
module mac_ve5_fp_int #(
    parameter int VAL_EBIAS = 15,
    parameter int WGT_EBIAS = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  mode,
    input  logic [15:0] value,
    input  logic [15:0] weight,
    input  logic [23:0] ints,
    input  logic [17:0] fps,
    output logic        out_valid,
    output logic [23:0] intr,
    output logic [17:0] fpr
);

    localparam logic [3:0] MODE_FP    = 4'd0;
    localparam logic [3:0] MODE_INT_S = 4'd1;
    localparam logic [3:0] MODE_INT_M = 4'd2;
    localparam logic [3:0] MODE_INT_L = 4'd3;

    // Exact fixed-point accumulator. LSB weight is the smallest possible product LSB,
    // 2^(2-VAL_EBIAS-WGT_EBIAS-22); 72 bits covers the largest product plus a sign bit.
    localparam int ACC_W       = 72;
    localparam int LSB_EXP     = 2 - VAL_EBIAS - WGT_EBIAS - 22;
    localparam int E_OFF       = LSB_EXP + VAL_EBIAS;
    localparam int BIAS_SH_OFF = WGT_EBIAS + 7;

    typedef struct packed {
        logic             vld;
        logic [3:0]       mode;
        logic [ACC_W-1:0] fp_prod;
        logic [ACC_W-1:0] fp_bias;
        logic [24:0]      int_prod;
        logic [23:0]      int_bias;
    } s1_t;

    s1_t s1_d, s1_q;

    // ---------------- S1: float decode, product, alignment ----------------
    logic [4:0]       val_e;
    logic [3:0]       wgt_e;
    logic             wgt_s;
    logic [11:0]      val_m;
    logic [11:0]      wgt_m;
    logic [4:0]       bias_e;
    logic [13:0]      bias_m;
    logic [23:0]      mant_p;
    logic [5:0]       prod_sh;
    logic [5:0]       bias_sh;
    logic [ACC_W-1:0] prod_mag;

    assign val_e    = value[15:11];
    assign val_m    = {1'b1, value[10:0]};
    assign wgt_s    = weight[15];
    assign wgt_e    = weight[14:11];
    assign wgt_m    = {1'b1, weight[10:0]};
    assign bias_e   = fps[17:13];
    assign bias_m   = {1'b1, fps[12:0]};
    assign mant_p   = 24'(val_m) * 24'(wgt_m);
    assign prod_sh  = 6'(val_e) + 6'(wgt_e) - 6'd2;
    assign bias_sh  = 6'(bias_e) + 6'(BIAS_SH_OFF);
    assign prod_mag = ACC_W'(mant_p) << prod_sh;

    // ---------------- S1: packed signed integer lanes ----------------
    logic signed [3:0]  va4 [4];
    logic signed [3:0]  wa4 [4];
    logic signed [7:0]  p4  [4];
    logic signed [7:0]  va8 [2];
    logic signed [7:0]  wa8 [2];
    logic signed [15:0] p8  [2];
    logic signed [11:0] va12;
    logic signed [11:0] wa12;
    logic signed [23:0] p12;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            va4[k] = value[4*k +: 4];
            wa4[k] = weight[4*k +: 4];
            p4[k]  = 8'(va4[k]) * 8'(wa4[k]);
        end
        for (int k = 0; k < 2; k++) begin
            va8[k] = value[8*k +: 8];
            wa8[k] = weight[8*k +: 8];
            p8[k]  = 16'(va8[k]) * 16'(wa8[k]);
        end
        va12 = value[11:0];
        wa12 = weight[11:0];
        p12  = 24'(va12) * 24'(wa12);
    end

    always_comb begin
        s1_d      = '0;
        s1_d.vld  = in_valid;
        s1_d.mode = mode;
        case (mode)
            MODE_FP: begin
                // Zero exponent field encodes an exact zero operand.
                if (val_e != 5'd0 && wgt_e != 4'd0)
                    s1_d.fp_prod = wgt_s ? (~prod_mag + 1'b1) : prod_mag;
                if (bias_e != 5'd0)
                    s1_d.fp_bias = ACC_W'(bias_m) << bias_sh;
            end
            MODE_INT_S: begin
                s1_d.int_prod = 25'(p4[0]) + 25'(p4[1]) + 25'(p4[2]) + 25'(p4[3]);
                s1_d.int_bias = ints;
            end
            MODE_INT_M: begin
                s1_d.int_prod = 25'(p8[0]) + 25'(p8[1]);
                s1_d.int_bias = ints;
            end
            MODE_INT_L: begin
                s1_d.int_prod = 25'(p12);
                s1_d.int_bias = ints;
            end
            default: ;
        endcase
    end

    // ---------------- S2: bias add, normalize, integer clamp ----------------
    logic [ACC_W-1:0] fp_sum;
    logic [6:0]       lead;
    int               exp_i;
    logic [12:0]      frac;
    logic [17:0]      fpr_d;
    logic [25:0]      int_sum;
    logic             int_ovf;
    logic [23:0]      intr_d;
    logic             is_int;

    always_comb begin
        fp_sum = s1_q.fp_prod + s1_q.fp_bias;
        lead   = '0;
        for (int i = 0; i < ACC_W; i++)
            if (fp_sum[i]) lead = 7'(i);
        exp_i = int'(lead) + E_OFF;
        // Dropping bits below the 13 kept fraction bits truncates toward zero (sum is positive here).
        frac  = 13'(fp_sum >> (lead - 7'd13));
        fpr_d = '0;
        if (s1_q.mode == MODE_FP && !fp_sum[ACC_W-1] && fp_sum != '0) begin
            if (exp_i > 31)
                fpr_d = '1;
            else if (exp_i >= 1)
                fpr_d = {exp_i[4:0], frac};
        end
    end

    always_comb begin
        is_int  = (s1_q.mode == MODE_INT_S) || (s1_q.mode == MODE_INT_M) ||
                  (s1_q.mode == MODE_INT_L);
        int_sum = 26'($signed(s1_q.int_prod)) + 26'($signed(s1_q.int_bias));
        int_ovf = (int_sum[25:23] != 3'b000) && (int_sum[25:23] != 3'b111);
        intr_d  = '0;
        if (is_int) begin
`ifdef MAC_VE5_SAT_EN
            if (int_ovf)
                intr_d = int_sum[25] ? 24'h800000 : 24'h7FFFFF;
            else
                intr_d = int_sum[23:0];
`else
            intr_d = int_sum[23:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            out_valid <= 1'b0;
            intr      <= '0;
            fpr       <= '0;
        end else begin
            s1_q      <= s1_d;
            out_valid <= s1_q.vld;
            intr      <= intr_d;
            fpr       <= fpr_d;
        end
    end

endmodule

// File: tb/tb_mac_ve5_fp_int.sv
// Directed bench for mac_ve5_fp_int: reset, float, integer lanes, overflow and back-to-back beats.
module tb_mac_ve5_fp_int;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  mode;
    logic [15:0] value;
    logic [15:0] weight;
    logic [23:0] ints;
    logic [17:0] fps;
    logic        out_valid;
    logic [23:0] intr;
    logic [17:0] fpr;

    always #5 clk = ~clk;

    mac_ve5_fp_int dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .mode     (mode),
        .value    (value),
        .weight   (weight),
        .ints     (ints),
        .fps      (fps),
        .out_valid(out_valid),
        .intr     (intr),
        .fpr      (fpr)
    );

    typedef struct {
        string       tag;
        logic [3:0]  m;
        logic [15:0] v;
        logic [15:0] w;
        logic [23:0] i;
        logic [17:0] f;
        logic [23:0] ei;
        logic [17:0] ef;
    } vec_t;

`ifdef MAC_VE5_SAT_EN
    localparam logic [23:0] OVF_POS = 24'h7FFFFF;
    localparam logic [23:0] OVF_NEG = 24'h800000;
`else
    localparam logic [23:0] OVF_POS = 24'h800000;
    localparam logic [23:0] OVF_NEG = 24'h400800;
`endif

    int passed = 0;
    int total  = 0;
    vec_t vecs[$];
    vec_t tp[8];

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic apply(input vec_t t);
        mode     = t.m;
        value    = t.v;
        weight   = t.w;
        ints     = t.i;
        fps      = t.f;
        in_valid = 1'b1;
    endtask

    task automatic check_out(input vec_t t);
        check({t.tag, ".vld"}, 24'(out_valid), 24'h1);
        check({t.tag, ".int"}, intr, t.ei);
        check({t.tag, ".fp"}, 24'(fpr), 24'(t.ef));
    endtask

    task automatic run_one(input vec_t t);
        @(negedge clk);
        apply(t);
        @(negedge clk);
        in_valid = 1'b0;
        check({t.tag, ".early"}, 24'(out_valid), 24'h0);
        @(negedge clk);
        check_out(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{"fp_main",  4'd0, 16'h7999, 16'h3999, 24'h123456, 18'h1E666, 24'h0,      18'h20A3A});
        vecs.push_back('{"fp_neg",   4'd0, 16'h7999, 16'hB999, 24'h0,      18'h00000, 24'h0,      18'h00000});
        vecs.push_back('{"fp_wzero", 4'd0, 16'h7999, 16'h0599, 24'h0,      18'h1E666, 24'h0,      18'h1E666});
        vecs.push_back('{"fp_sat",   4'd0, 16'hF800, 16'h7800, 24'h0,      18'h00000, 24'h0,      18'h3FFFF});
        vecs.push_back('{"fp_min",   4'd0, 16'h0800, 16'h3800, 24'h0,      18'h00000, 24'h0,      18'h02000});
        vecs.push_back('{"fp_under", 4'd0, 16'h0800, 16'h3000, 24'h0,      18'h00000, 24'h0,      18'h00000});
        vecs.push_back('{"fp_cancel",4'd0, 16'h7800, 16'hB800, 24'h0,      18'h20000, 24'h0,      18'h1E000});
        vecs.push_back('{"int_s",    4'd1, 16'h1111, 16'hFFFF, 24'h0,      18'h1E666, 24'hFFFFFC, 18'h00000});
        vecs.push_back('{"int_s_mix",4'd1, 16'h8731, 16'h2F7F, 24'h000010, 18'h00000, 24'h00000D, 18'h00000});
        vecs.push_back('{"int_m",    4'd2, 16'h0302, 16'h04FF, 24'h000005, 18'h00000, 24'h00000F, 18'h00000});
        vecs.push_back('{"int_l",    4'd3, 16'hF7FF, 16'hA7FF, 24'h400000, 18'h00000, 24'h7FF001, 18'h00000});
        vecs.push_back('{"ovf_pos",  4'd3, 16'h0001, 16'h0001, 24'h7FFFFF, 18'h00000, OVF_POS,    18'h00000});
        vecs.push_back('{"ovf_neg",  4'd3, 16'h0800, 16'h07FF, 24'h800000, 18'h00000, OVF_NEG,    18'h00000});
        vecs.push_back('{"reserved", 4'd5, 16'h1111, 16'hFFFF, 24'h000123, 18'h1E666, 24'h0,      18'h00000});

        rst_n    = 1'b0;
        in_valid = 1'b0;
        mode     = 4'd0;
        value    = '0;
        weight   = '0;
        ints     = '0;
        fps      = '0;

        #2;
        check("rst.vld", 24'(out_valid), 24'h0);
        check("rst.int", intr, 24'h0);
        check("rst.fp", 24'(fpr), 24'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[n]) run_one(vecs[n]);

        // Back-to-back beats with alternating modes.
        tp[0] = vecs[0];
        tp[1] = vecs[7];
        tp[2] = vecs[9];
        tp[3] = vecs[10];
        tp[4] = vecs[3];
        tp[5] = vecs[13];
        tp[6] = vecs[8];
        tp[7] = vecs[6];
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j >= 2) check_out(tp[j-2]);
            else check("tp.idle", 24'(out_valid), 24'h0);
            if (j < 8) apply(tp[j]);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        check("tp.tail", 24'(out_valid), 24'h0);

        // Asynchronous reset with beats in flight.
        @(negedge clk);
        apply(vecs[9]);
        @(negedge clk);
        apply(vecs[0]);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid.vld", 24'(out_valid), 24'h1);
        check("mid.int", intr, 24'h00000F);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.vld", 24'(out_valid), 24'h0);
        check("arst.int", intr, 24'h0);
        check("arst.fp", 24'(fpr), 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("arst.nopulse", 24'(out_valid), 24'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
